// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: register offsets and address-split helpers shared by the GPIO port
package cpu_io_pkg;
  localparam logic [1:0] IO_REG_IN  = 2'd0;
  localparam logic [1:0] IO_REG_OUT = 2'd1;
  localparam logic [1:0] IO_REG_IE  = 2'd2;
  localparam logic [1:0] IO_REG_IS  = 2'd3;
  localparam int IO_REG_W = 2;
  function automatic int io_addr_w(input int nch);
    return (nch <= 1) ? IO_REG_W : $clog2(nch) + IO_REG_W;
  endfunction
endpackage

// File: rtl/io_sync_edge.sv
// io_sync_edge: per-channel pin synchroniser with previous-value register and rising-edge detect
//   clk, rst (async active-low) | pin_i: raw async pins | in_o: synchronised value | rise_o: in_o & ~prev
module io_sync_edge #(
  parameter int W           = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] in_o,
  output logic [W-1:0] rise_o
);
  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]                  prev_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign in_o   = sync_q[SYNC_STAGES-1];
  assign rise_o = in_o & ~prev_q;
endmodule

// File: rtl/cpu_io_port.sv
// cpu_io_port: memory-mapped GPIO port, NCH channels of IN/OUT/IE/IS registers with level irq
//   clk, rst (async active-low)
//   bus_addr/bus_we/bus_re/bus_wdata: CPU access, addr = {channel, reg}
//   bus_rdata/bus_rvalid: read data one cycle after bus_re
//   pin_in/pin_out: channel c at [c*W +: W] | irq: registered |(IS & IE)
module cpu_io_port
  import cpu_io_pkg::*;
#(
  parameter  int NCH         = 2,
  parameter  int W           = 32,
  parameter  int SYNC_STAGES = 2,
  localparam int AW          = io_addr_w(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     bus_addr,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [W-1:0]      bus_wdata,
  output logic [W-1:0]      bus_rdata,
  output logic              bus_rvalid,
  input  logic [NCH*W-1:0]  pin_in,
  output logic [NCH*W-1:0]  pin_out,
  output logic              irq
);
  logic [NCH-1:0][W-1:0] out_q, out_d, ie_q, ie_d, is_q, is_d, in_w, rise_w;
  logic [W-1:0]          rdata_q, rdata_d, rd_val;
  logic                  rvalid_q, irq_q;
  logic [AW-1:0]         ch_idx;
  logic [1:0]            rg;
  assign ch_idx = bus_addr >> IO_REG_W;
  assign rg     = bus_addr[1:0];
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    io_sync_edge #(.W(W), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (pin_in[g*W +: W]),
      .in_o   (in_w[g]),
      .rise_o (rise_w[g])
    );
  end
  // Channel indices >= NCH match no loop iteration: writes drop, reads yield 0.
  // IS clears against the old value and new rises are OR-ed last, so a set wins over a same-cycle clear.
  always_comb begin
    out_d  = out_q;
    ie_d   = ie_q;
    is_d   = is_q;
    rd_val = '0;
    for (int c = 0; c < NCH; c++) begin
      out_d[c] = (bus_we && ch_idx == AW'(c) && rg == IO_REG_OUT) ? bus_wdata : out_q[c];
      ie_d[c]  = (bus_we && ch_idx == AW'(c) && rg == IO_REG_IE) ? bus_wdata : ie_q[c];
      is_d[c]  = (is_q[c] & ~((bus_we && ch_idx == AW'(c) && rg == IO_REG_IS) ? bus_wdata : '0)) | rise_w[c];
      if (ch_idx == AW'(c))
        rd_val = rg == IO_REG_IN  ? in_w[c] :
                 rg == IO_REG_OUT ? out_q[c] :
                 rg == IO_REG_IE  ? ie_q[c] : is_q[c];
    end
    rdata_d = bus_re ? rd_val : rdata_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q    <= '0;
      ie_q     <= '0;
      is_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      ie_q     <= ie_d;
      is_q     <= is_d;
      rdata_q  <= rdata_d;
      rvalid_q <= bus_re;
      irq_q    <= |(is_q & ie_q);
    end
  end
  assign pin_out    = out_q;
  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq        = irq_q;
endmodule
